wbi_master_node: RTL and testbench

// - Master-side end of the WB interconnect node pair: turns a core's burst Wishbone master port into the

---
 rtl/wbi_pkg.sv | 17 +
 rtl/wbi_cmd_reg.sv | 55 +++++
 rtl/wbi_master_node.sv | 232 +++++++++++++++++++++++
 tb/tb_wbi_master_node.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wbi_pkg.sv
// Shared definitions for the WB interconnect master node.
// Holds the node FSM state type and the widths of the transaction id and
// the optional response-timeout counter.
package wbi_pkg;

  localparam int WBI_TID_W = 4;
  localparam int WBI_TMO_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_WAIT,
    DRAIN
  } wbi_mn_state_t;

endpackage

// File: rtl/wbi_cmd_reg.sv
// Single-entry command holding register with a val/rdy handshake.
// The payload and valid flag stay stable until the entry is accepted
// (val_o & rdy_i) or withdrawn. A load takes priority over both, so a new
// entry can follow an accept in the same cycle without a bubble.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i, data_i    write a new entry (sets val)
//   withdraw_i        drop a pending entry without transferring it
//   rdy_i             consumer ready
//   val_o, data_o     held entry
//   xfer_o            entry transferred this cycle
module wbi_cmd_reg #(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          withdraw_i,
  input  logic [PW-1:0] data_i,
  input  logic          rdy_i,
  output logic          val_o,
  output logic [PW-1:0] data_o,
  output logic          xfer_o
);

  logic          val_q, val_d;
  logic [PW-1:0] data_q, data_d;

  assign xfer_o = val_q & rdy_i;
  assign val_o  = val_q;
  assign data_o = data_q;

  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    if (xfer_o || withdraw_i) begin
      val_d = 1'b0;
    end
    if (load_i) begin
      val_d  = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/wbi_master_node.sv
// Master-side end of the WB interconnect node pair. Converts a burst
// Wishbone master port into the interconnect command stream (val/wrdy) and
// the response stream (rval/rrdy) back into WB beat acks.
// Writes are posted, one command per data beat; a read issues one command
// and its data returns beat by beat.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   wbm_*_i / wbm_*_o             WB burst master port (cyc/stb/we/adr/dat/sel/bl/bry, dat/ack/lack/err)
//   wbd_cmd_wrdy_i, wbd_cmd_*_o   registered command stream to the fabric
//   wbd_res_*_i, wbd_res_rrdy_o   response stream from the fabric
// Build option:
//   WBI_MN_TIMEOUT_EN  adds a 16-bit no-response timeout in RD_WAIT/DRAIN.
module wbi_master_node
  import wbi_pkg::*;
#(
  parameter int                   AW  = 32,
  parameter int                   DW  = 32,
  parameter int                   BW  = 4,
  parameter int                   BL  = 10,
  parameter logic [WBI_TID_W-1:0] TID = 4'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wbm_cyc_i,
  input  logic                 wbm_stb_i,
  input  logic                 wbm_we_i,
  input  logic [AW-1:0]        wbm_adr_i,
  input  logic [DW-1:0]        wbm_dat_i,
  input  logic [BW-1:0]        wbm_sel_i,
  input  logic [BL-1:0]        wbm_bl_i,
  input  logic                 wbm_bry_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic                 wbm_ack_o,
  output logic                 wbm_lack_o,
  output logic                 wbm_err_o,
  input  logic                 wbd_cmd_wrdy_i,
  output logic                 wbd_cmd_val_o,
  output logic [AW-1:0]        wbd_cmd_adr_o,
  output logic                 wbd_cmd_we_o,
  output logic [DW-1:0]        wbd_cmd_dat_o,
  output logic [BW-1:0]        wbd_cmd_sel_o,
  output logic [WBI_TID_W-1:0] wbd_cmd_tid_o,
  output logic [BL-1:0]        wbd_cmd_bl_o,
  input  logic                 wbd_res_rval_i,
  output logic                 wbd_res_rrdy_o,
  input  logic [DW-1:0]        wbd_res_dat_i,
  input  logic                 wbd_res_lack_i,
  input  logic                 wbd_res_err_i,
  input  logic [WBI_TID_W-1:0] wbd_res_tid_i
);

  // Command payload layout, MSB first: adr, we, dat, sel, tid, bl.
  localparam int PW      = AW + 1 + DW + BW + WBI_TID_W + BL;
  localparam int DAT_LSB = BW + WBI_TID_W + BL;

  wbi_mn_state_t state_q, state_d;
  logic [BL-1:0] cnt_q, cnt_d;
  logic [BL-1:0] bl_eff;
  logic          cnt_last;

  logic          load, withdraw;
  logic [PW-1:0] load_data, cmd_data;
  logic          cmd_xfer;
  logic          res_xfer;

  logic          start_wr, start_rd;

`ifdef WBI_MN_TIMEOUT_EN
  logic [WBI_TMO_W-1:0] tmo_q, tmo_d;
`endif

  wbi_cmd_reg #(.PW(PW)) u_cmd_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .withdraw_i (withdraw),
    .data_i     (load_data),
    .rdy_i      (wbd_cmd_wrdy_i),
    .val_o      (wbd_cmd_val_o),
    .data_o     (cmd_data),
    .xfer_o     (cmd_xfer)
  );

  assign {wbd_cmd_adr_o, wbd_cmd_we_o, wbd_cmd_dat_o,
          wbd_cmd_sel_o, wbd_cmd_tid_o, wbd_cmd_bl_o} = cmd_data;

  // A burst length of zero behaves as a single beat.
  assign bl_eff   = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
  assign cnt_last = (cnt_q == BL'(1));

  assign start_wr = wbm_cyc_i & wbm_stb_i & wbm_we_i & wbm_bry_i;
  assign start_rd = wbm_cyc_i & wbm_stb_i & ~wbm_we_i;

  // IDLE and DRAIN always sink responses so stale fabric traffic cannot
  // stall; in RD_WAIT the master's bry paces the returning data.
  always_comb begin
    case (state_q)
      RD_WAIT: wbd_res_rrdy_o = wbm_bry_i;
      RD_CMD:  wbd_res_rrdy_o = 1'b0;
      WR:      wbd_res_rrdy_o = 1'b0;
      default: wbd_res_rrdy_o = 1'b1;
    endcase
  end

  assign res_xfer = wbd_res_rval_i & wbd_res_rrdy_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    withdraw   = 1'b0;
    load_data  = cmd_data;
    wbm_dat_o  = '0;
    wbm_ack_o  = 1'b0;
    wbm_lack_o = 1'b0;
    wbm_err_o  = 1'b0;
`ifdef WBI_MN_TIMEOUT_EN
    tmo_d      = '0;
`endif

    // Follow-on write beats reuse the captured header with fresh wdata.
    load_data[DAT_LSB +: DW] = wbm_dat_i;

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          load      = 1'b1;
          load_data = {wbm_adr_i, 1'b1, wbm_dat_i, wbm_sel_i, TID, wbm_bl_i};
          cnt_d     = bl_eff;
          state_d   = WR;
        end else if (start_rd) begin
          load      = 1'b1;
          load_data = {wbm_adr_i, 1'b0, {DW{1'b0}}, wbm_sel_i, TID, wbm_bl_i};
          cnt_d     = bl_eff;
          state_d   = RD_CMD;
        end
      end

      WR: begin
        if (cmd_xfer) begin
          // An accept that coincides with a cyc drop still completes the beat.
          wbm_ack_o = 1'b1;
          cnt_d     = cnt_q - BL'(1);
          if (cnt_last) begin
            wbm_lack_o = 1'b1;
            state_d    = IDLE;
          end else if (!wbm_cyc_i) begin
            state_d = IDLE;
          end else if (wbm_bry_i) begin
            load = 1'b1;
          end
        end else if (!wbm_cyc_i) begin
          withdraw = 1'b1;
          state_d  = IDLE;
        end else if (!wbd_cmd_val_o && wbm_bry_i) begin
          load = 1'b1;
        end
      end

      RD_CMD: begin
        if (cmd_xfer) begin
          state_d = wbm_cyc_i ? RD_WAIT : DRAIN;
        end else if (!wbm_cyc_i) begin
          withdraw = 1'b1;
          state_d  = IDLE;
        end
      end

      RD_WAIT: begin
        if (!wbm_cyc_i) begin
          // The abort cycle may itself carry the final response.
          state_d = (res_xfer && wbd_res_lack_i) ? IDLE : DRAIN;
        end else if (res_xfer) begin
          wbm_ack_o  = 1'b1;
          wbm_dat_o  = wbd_res_dat_i;
          wbm_err_o  = wbd_res_err_i | (wbd_res_tid_i != TID);
          wbm_lack_o = wbd_res_lack_i | cnt_last;
          cnt_d      = cnt_q - BL'(1);
          if (wbd_res_lack_i || cnt_last) begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (res_xfer && wbd_res_lack_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef WBI_MN_TIMEOUT_EN
    // Silence from the fabric for a full counter period ends the read with
    // an error so the master is never stuck.
    if (state_q == RD_WAIT || state_q == DRAIN) begin
      tmo_d = res_xfer ? '0 : tmo_q + WBI_TMO_W'(1);
      if (!res_xfer && tmo_q == '1) begin
        tmo_d   = '0;
        state_d = IDLE;
        if (state_q == RD_WAIT) begin
          wbm_ack_o  = 1'b1;
          wbm_lack_o = 1'b1;
          wbm_err_o  = 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WBI_MN_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_wbi_master_node.sv
// Directed self-checking bench for wbi_master_node (default build).
// Inputs change 1ns after each rising edge; outputs are sampled 2ns later.
module tb_wbi_master_node;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_bry_i;
  logic [31:0] wbm_adr_i, wbm_dat_i;
  logic [3:0]  wbm_sel_i;
  logic [9:0]  wbm_bl_i;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_o, wbm_lack_o, wbm_err_o;
  logic        wbd_cmd_wrdy_i, wbd_cmd_val_o, wbd_cmd_we_o;
  logic [31:0] wbd_cmd_adr_o, wbd_cmd_dat_o;
  logic [3:0]  wbd_cmd_sel_o, wbd_cmd_tid_o;
  logic [9:0]  wbd_cmd_bl_o;
  logic        wbd_res_rval_i, wbd_res_rrdy_o, wbd_res_lack_i, wbd_res_err_i;
  logic [31:0] wbd_res_dat_i;
  logic [3:0]  wbd_res_tid_i;

  int tests = 0;
  int fails = 0;

  wbi_master_node dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_bl_i(wbm_bl_i), .wbm_bry_i(wbm_bry_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_lack_o(wbm_lack_o), .wbm_err_o(wbm_err_o),
    .wbd_cmd_wrdy_i(wbd_cmd_wrdy_i), .wbd_cmd_val_o(wbd_cmd_val_o),
    .wbd_cmd_adr_o(wbd_cmd_adr_o), .wbd_cmd_we_o(wbd_cmd_we_o), .wbd_cmd_dat_o(wbd_cmd_dat_o),
    .wbd_cmd_sel_o(wbd_cmd_sel_o), .wbd_cmd_tid_o(wbd_cmd_tid_o), .wbd_cmd_bl_o(wbd_cmd_bl_o),
    .wbd_res_rval_i(wbd_res_rval_i), .wbd_res_rrdy_o(wbd_res_rrdy_o),
    .wbd_res_dat_i(wbd_res_dat_i), .wbd_res_lack_i(wbd_res_lack_i),
    .wbd_res_err_i(wbd_res_err_i), .wbd_res_tid_i(wbd_res_tid_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0; wbm_bry_i = 0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_bl_i = '0;
    wbd_cmd_wrdy_i = 0; wbd_res_rval_i = 0; wbd_res_dat_i = '0;
    wbd_res_lack_i = 0; wbd_res_err_i = 0; wbd_res_tid_i = '0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    clear_inputs();
    tick(); tick(); #2;
    tests++; if (wbd_cmd_val_o !== 1'b0) begin fails++; $display("[TB] FAIL rst_val: got %b want 0", wbd_cmd_val_o); end
    tests++; if ({wbm_ack_o, wbm_lack_o, wbm_err_o} !== 3'b000) begin fails++; $display("[TB] FAIL rst_acks: got %b want 000", {wbm_ack_o, wbm_lack_o, wbm_err_o}); end
    tests++; if (wbm_dat_o !== 32'h0) begin fails++; $display("[TB] FAIL rst_dat: got %h want 0", wbm_dat_o); end
    tests++; if (wbd_res_rrdy_o !== 1'b1) begin fails++; $display("[TB] FAIL rst_rrdy: got %b want 1", wbd_res_rrdy_o); end
    tick(); rst_i = 1'b0;
  endtask

  task automatic test_single_write;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h1000_0040;
    wbm_dat_i = 32'hDEAD_BEEF; wbm_sel_i = 4'hF; wbm_bl_i = 10'd1; wbd_cmd_wrdy_i = 1; #2;
    tests++; if (wbd_cmd_val_o !== 1'b0) begin fails++; $display("[TB] FAIL sw_val_early: got %b want 0", wbd_cmd_val_o); end
    tick(); wbm_stb_i = 0; wbm_bry_i = 0; #2;
    tests++; if (wbd_cmd_val_o !== 1'b1) begin fails++; $display("[TB] FAIL sw_val: got %b want 1", wbd_cmd_val_o); end
    tests++; if (wbd_cmd_adr_o !== 32'h1000_0040) begin fails++; $display("[TB] FAIL sw_adr: got %h want 10000040", wbd_cmd_adr_o); end
    tests++; if (wbd_cmd_dat_o !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL sw_dat: got %h want deadbeef", wbd_cmd_dat_o); end
    tests++; if ({wbd_cmd_we_o, wbd_cmd_tid_o, wbd_cmd_sel_o} !== {1'b1, 4'h0, 4'hF}) begin fails++; $display("[TB] FAIL sw_we_tid_sel: got %h want 10f", {wbd_cmd_we_o, wbd_cmd_tid_o, wbd_cmd_sel_o}); end
    tests++; if (wbd_cmd_bl_o !== 10'd1) begin fails++; $display("[TB] FAIL sw_bl: got %0d want 1", wbd_cmd_bl_o); end
    tests++; if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin fails++; $display("[TB] FAIL sw_ack_lack: got %b want 11", {wbm_ack_o, wbm_lack_o}); end
    tick(); wbm_cyc_i = 0; wbd_cmd_wrdy_i = 0; #2;
    tests++; if ({wbd_cmd_val_o, wbm_ack_o, wbd_res_rrdy_o} !== 3'b001) begin fails++; $display("[TB] FAIL sw_idle: got val/ack/rrdy %b want 001", {wbd_cmd_val_o, wbm_ack_o, wbd_res_rrdy_o}); end
  endtask

  task automatic test_write_burst;
    logic        wrdy_seq [5];
    logic [31:0] din      [5];
    logic [31:0] exp_dat  [5];
    logic        exp_ack  [5];
    logic        exp_lack [5];
    wrdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    din      = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0003};
    exp_dat  = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
    exp_ack  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_lack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h3000_0100;
    wbm_dat_i = 32'hA0A0_0000; wbm_sel_i = 4'h3; wbm_bl_i = 10'd4; wbd_cmd_wrdy_i = 0; #2;
    for (int i = 0; i < 5; i++) begin
      tick();
      wbd_cmd_wrdy_i = wrdy_seq[i]; wbm_dat_i = din[i];
      if (i == 4) begin wbm_stb_i = 0; wbm_bry_i = 0; end
      #2;
      tests++; if (wbd_cmd_val_o !== 1'b1) begin fails++; $display("[TB] FAIL wb_val[%0d]: got %b want 1", i, wbd_cmd_val_o); end
      tests++; if (wbd_cmd_dat_o !== exp_dat[i]) begin fails++; $display("[TB] FAIL wb_dat[%0d]: got %h want %h", i, wbd_cmd_dat_o, exp_dat[i]); end
      tests++; if ({wbm_ack_o, wbm_lack_o} !== {exp_ack[i], exp_lack[i]}) begin fails++; $display("[TB] FAIL wb_ack_lack[%0d]: got %b want %b", i, {wbm_ack_o, wbm_lack_o}, {exp_ack[i], exp_lack[i]}); end
      tests++; if ({wbd_cmd_adr_o, wbd_cmd_bl_o} !== {32'h3000_0100, 10'd4}) begin fails++; $display("[TB] FAIL wb_hdr[%0d]: got %h/%0d want 30000100/4", i, wbd_cmd_adr_o, wbd_cmd_bl_o); end
    end
    tick(); wbm_cyc_i = 0; wbd_cmd_wrdy_i = 0; #2;
    tests++; if ({wbd_cmd_val_o, wbd_res_rrdy_o} !== 2'b01) begin fails++; $display("[TB] FAIL wb_idle: got val/rrdy %b want 01", {wbd_cmd_val_o, wbd_res_rrdy_o}); end
  endtask

  task automatic test_bry_gap;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h3000_0200;
    wbm_dat_i = 32'hE0E0_0000; wbm_sel_i = 4'hF; wbm_bl_i = 10'd2; wbd_cmd_wrdy_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 1; wbm_bry_i = 0; #2;
    tests++; if ({wbm_ack_o, wbm_lack_o} !== 2'b10) begin fails++; $display("[TB] FAIL gap_ack1: got %b want 10", {wbm_ack_o, wbm_lack_o}); end
    tick(); #2;
    tests++; if ({wbd_cmd_val_o, wbm_ack_o} !== 2'b00) begin fails++; $display("[TB] FAIL gap_bubble: got val/ack %b want 00", {wbd_cmd_val_o, wbm_ack_o}); end
    tick(); wbm_bry_i = 1; wbm_dat_i = 32'hE0E0_0001; #2;
    tests++; if (wbd_cmd_val_o !== 1'b0) begin fails++; $display("[TB] FAIL gap_reload_early: got %b want 0", wbd_cmd_val_o); end
    tick(); wbm_bry_i = 0; wbm_stb_i = 0; #2;
    tests++; if ({wbd_cmd_val_o, wbd_cmd_dat_o} !== {1'b1, 32'hE0E0_0001}) begin fails++; $display("[TB] FAIL gap_beat2: got %b/%h want 1/e0e00001", wbd_cmd_val_o, wbd_cmd_dat_o); end
    tests++; if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin fails++; $display("[TB] FAIL gap_lack: got %b want 11", {wbm_ack_o, wbm_lack_o}); end
    tick(); wbm_cyc_i = 0; wbd_cmd_wrdy_i = 0; #2;
  endtask

  task automatic test_read_burst;
    logic        rbry  [4];
    logic [31:0] rdat  [4];
    logic        rlack [4];
    logic [3:0]  exp   [4];
    rbry  = '{1'b0, 1'b1, 1'b1, 1'b1};
    rdat  = '{32'h11, 32'h11, 32'h22, 32'h33};
    rlack = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp   = '{4'b0000, 4'b1100, 4'b1100, 4'b1110};
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_bry_i = 1; wbm_adr_i = 32'h2000_0000;
    wbm_sel_i = 4'hF; wbm_bl_i = 10'd3; wbd_cmd_wrdy_i = 0; #2;
    tick(); #2;
    tests++; if ({wbd_cmd_val_o, wbd_cmd_we_o, wbd_cmd_bl_o, wbd_cmd_tid_o} !== {1'b1, 1'b0, 10'd3, 4'h0}) begin fails++; $display("[TB] FAIL rd_cmd: got val/we/bl/tid %b/%b/%0d/%h want 1/0/3/0", wbd_cmd_val_o, wbd_cmd_we_o, wbd_cmd_bl_o, wbd_cmd_tid_o); end
    tests++; if (wbd_cmd_adr_o !== 32'h2000_0000) begin fails++; $display("[TB] FAIL rd_adr: got %h want 20000000", wbd_cmd_adr_o); end
    tick(); wbd_cmd_wrdy_i = 1; wbm_stb_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 0; wbd_res_rval_i = 1; #2;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      wbm_bry_i = rbry[i]; wbd_res_dat_i = rdat[i]; wbd_res_lack_i = rlack[i]; #1;
      tests++; if ({wbm_ack_o, wbd_res_rrdy_o, wbm_lack_o, wbm_err_o} !== exp[i]) begin fails++; $display("[TB] FAIL rd_beat[%0d]: got ack/rrdy/lack/err %b want %b", i, {wbm_ack_o, wbd_res_rrdy_o, wbm_lack_o, wbm_err_o}, exp[i]); end
      tests++; if (exp[i][3] && wbm_dat_o !== rdat[i]) begin fails++; $display("[TB] FAIL rd_dat[%0d]: got %h want %h", i, wbm_dat_o, rdat[i]); end
    end
    tick(); wbd_res_rval_i = 0; wbd_res_lack_i = 0; wbm_cyc_i = 0; #2;
    tests++; if ({wbm_ack_o, wbd_res_rrdy_o, wbd_cmd_val_o} !== 3'b010) begin fails++; $display("[TB] FAIL rd_idle: got ack/rrdy/val %b want 010", {wbm_ack_o, wbd_res_rrdy_o, wbd_cmd_val_o}); end
  endtask

  task automatic test_read_tid_err;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_bry_i = 1; wbm_adr_i = 32'h2000_0100;
    wbm_bl_i = 10'd2; wbd_cmd_wrdy_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 1; wbm_stb_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 0; wbd_res_rval_i = 1; wbd_res_dat_i = 32'h55; wbd_res_tid_i = 4'h5; #2;
    tests++; if ({wbm_ack_o, wbm_err_o, wbm_lack_o} !== 3'b110) begin fails++; $display("[TB] FAIL tid_err: got ack/err/lack %b want 110", {wbm_ack_o, wbm_err_o, wbm_lack_o}); end
    tick(); wbd_res_dat_i = 32'h66; wbd_res_tid_i = 4'h0; #2;
    tests++; if ({wbm_ack_o, wbm_err_o, wbm_lack_o} !== 3'b101) begin fails++; $display("[TB] FAIL tid_cnt_lack: got ack/err/lack %b want 101", {wbm_ack_o, wbm_err_o, wbm_lack_o}); end
    tick(); wbd_res_rval_i = 0; wbm_cyc_i = 0; #2;
    tests++; if ({wbm_ack_o, wbd_res_rrdy_o} !== 2'b01) begin fails++; $display("[TB] FAIL tid_idle: got ack/rrdy %b want 01", {wbm_ack_o, wbd_res_rrdy_o}); end
  endtask

  task automatic test_read_abort;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_bry_i = 1; wbm_adr_i = 32'h2000_0200;
    wbm_bl_i = 10'd4; wbd_cmd_wrdy_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 1; wbm_stb_i = 0; #2;
    tick(); wbd_cmd_wrdy_i = 0; wbd_res_rval_i = 1; wbd_res_dat_i = 32'hA1; #2;
    tests++; if ({wbm_ack_o, wbm_dat_o} !== {1'b1, 32'hA1}) begin fails++; $display("[TB] FAIL ab_beat1: got %b/%h want 1/a1", wbm_ack_o, wbm_dat_o); end
    tick(); wbd_res_rval_i = 0; wbm_cyc_i = 0; #2;
    for (int i = 0; i < 3; i++) begin
      tick(); wbm_bry_i = 0; wbd_res_rval_i = 1; wbd_res_dat_i = 32'hA2 + i; wbd_res_lack_i = (i == 2); #2;
      tests++; if ({wbm_ack_o, wbd_res_rrdy_o} !== 2'b01) begin fails++; $display("[TB] FAIL ab_drain[%0d]: got ack/rrdy %b want 01", i, {wbm_ack_o, wbd_res_rrdy_o}); end
    end
    tick(); wbd_res_rval_i = 0; wbd_res_lack_i = 0;
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h1000_0080;
    wbm_dat_i = 32'hCAFE_F00D; wbm_bl_i = 10'd1; wbd_cmd_wrdy_i = 1; #2;
    tick(); wbm_stb_i = 0; wbm_bry_i = 0; #2;
    tests++; if ({wbd_cmd_val_o, wbd_cmd_dat_o} !== {1'b1, 32'hCAFE_F00D}) begin fails++; $display("[TB] FAIL ab_next_wr: got %b/%h want 1/cafef00d", wbd_cmd_val_o, wbd_cmd_dat_o); end
    tests++; if ({wbm_ack_o, wbm_lack_o} !== 2'b11) begin fails++; $display("[TB] FAIL ab_next_ack: got %b want 11", {wbm_ack_o, wbm_lack_o}); end
    tick(); wbm_cyc_i = 0; wbd_cmd_wrdy_i = 0; #2;
  endtask

  task automatic test_write_abort;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h3000_0300;
    wbm_dat_i = 32'hF0F0_0000; wbm_bl_i = 10'd3; wbd_cmd_wrdy_i = 0; #2;
    tick(); #2;
    tests++; if ({wbd_cmd_val_o, wbm_ack_o} !== 2'b10) begin fails++; $display("[TB] FAIL wa_pending: got val/ack %b want 10", {wbd_cmd_val_o, wbm_ack_o}); end
    tick(); wbm_cyc_i = 0; wbm_stb_i = 0; #2;
    tests++; if (wbm_ack_o !== 1'b0) begin fails++; $display("[TB] FAIL wa_noack: got %b want 0", wbm_ack_o); end
    tick(); wbd_cmd_wrdy_i = 1; #2;
    tests++; if ({wbd_cmd_val_o, wbm_ack_o, wbd_res_rrdy_o} !== 3'b001) begin fails++; $display("[TB] FAIL wa_withdrawn: got val/ack/rrdy %b want 001", {wbd_cmd_val_o, wbm_ack_o, wbd_res_rrdy_o}); end
    wbd_cmd_wrdy_i = 0;
  endtask

  task automatic test_bl_zero;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h1000_00C0;
    wbm_dat_i = 32'h0BAD_0000; wbm_bl_i = 10'd0; wbd_cmd_wrdy_i = 1; #2;
    tick(); wbm_stb_i = 0; wbm_bry_i = 0; #2;
    tests++; if ({wbd_cmd_bl_o, wbm_ack_o, wbm_lack_o} !== {10'd0, 2'b11}) begin fails++; $display("[TB] FAIL bl0: got bl/ack/lack %0d/%b%b want 0/11", wbd_cmd_bl_o, wbm_ack_o, wbm_lack_o); end
    tick(); wbm_cyc_i = 0; wbd_cmd_wrdy_i = 0; #2;
    tests++; if (wbd_cmd_val_o !== 1'b0) begin fails++; $display("[TB] FAIL bl0_idle: got %b want 0", wbd_cmd_val_o); end
  endtask

  task automatic test_idle_stale_response;
    tick(); wbd_res_rval_i = 1; wbd_res_dat_i = 32'h77; wbd_res_lack_i = 1; #2;
    tests++; if ({wbd_res_rrdy_o, wbm_ack_o, wbm_dat_o} !== {2'b10, 32'h0}) begin fails++; $display("[TB] FAIL stale: got rrdy/ack/dat %b%b/%h want 10/0", wbd_res_rrdy_o, wbm_ack_o, wbm_dat_o); end
    tick(); wbd_res_rval_i = 0; wbd_res_lack_i = 0; #2;
  endtask

  task automatic test_reset_mid_burst;
    tick();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_bry_i = 1; wbm_adr_i = 32'h3000_0400;
    wbm_dat_i = 32'h1234_5678; wbm_bl_i = 10'd4; wbd_cmd_wrdy_i = 0; #2;
    tick(); wbm_stb_i = 0; #2;
    tick(); rst_i = 1; #2;
    tick(); rst_i = 0; wbm_bry_i = 0; #2;
    tests++; if ({wbd_cmd_val_o, wbd_res_rrdy_o, wbm_ack_o} !== 3'b010) begin fails++; $display("[TB] FAIL rst_mid: got val/rrdy/ack %b want 010", {wbd_cmd_val_o, wbd_res_rrdy_o, wbm_ack_o}); end
    tick(); wbm_cyc_i = 0; #2;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_burst();
    test_bry_gap();
    test_read_burst();
    test_read_tid_err();
    test_read_abort();
    test_write_abort();
    test_bl_zero();
    test_idle_stale_response();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
